// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port main-memory arbiter: FSM state
// encoding, owner codes and the default line width.
// Optional feature macro (used by mem_arb_pick / mem_arbiter): MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int DEFAULT_LINE_SIZE = 128;
    localparam int DEFAULT_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_I    = 2'b01;
    localparam logic [1:0] OWNER_D    = 2'b10;

    // Owner code visible on the port for a given arbiter state; only the
    // serving states own the memory.
    function automatic logic [1:0] owner_of(input arb_state_t st);
        logic [1:0] owner;
        owner = OWNER_NONE;
        if (st == ST_SERVE_I) begin
            owner = OWNER_I;
        end else if (st == ST_SERVE_D) begin
            owner = OWNER_D;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the I-cache and D-cache requests. This is the only
// place the arbitration policy lives.
// MEM_ARB_RR_EN defined: round-robin on ties (side not served last wins).
// MEM_ARB_RR_EN undefined: fixed priority, D always beats I.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_was_d,
`endif
    output logic grant_i,
    output logic grant_d
);

    // At most one grant; a lone requester always wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            if (last_was_d) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
`else
        // D stalls freeze the whole pipeline, so D is never kept waiting.
        grant_d = d_req;
        grant_i = i_req & ~d_req;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port main-memory arbiter: I-cache and D-cache share one line-wide
// memory port. One requester is granted at a time; its command is latched
// in IDLE and replayed to memory for the whole grant, completion and read
// data are routed back to that requester only, then one turnaround cycle.
// A sticky watchdog flags grants that last TIMEOUT_CYCLES (0 = off).
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of D priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = DEFAULT_LINE_SIZE,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_i_read_en,
    input  logic                       in_i_write_en,
    input  logic [31:0]                in_i_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_i_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
    output logic                       out_i_ready,
    input  logic                       in_d_read_en,
    input  logic                       in_d_write_en,
    input  logic [31:0]                in_d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
    output logic                       out_d_ready,
    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [31:0]                out_mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
    input  logic                       in_mem_ready,
    output logic [1:0]                 out_owner,
    output logic                       out_timeout
);

    // Watchdog counter is at least 8 bits and always wide enough to hold
    // the limit, so the compare below can actually be reached.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t                 state_reg;
    arb_state_t                 state_next;
    logic [31:0]                addr_reg;
    logic [CACHE_LINE_SIZE-1:0] wdata_reg;
    logic                       write_reg;
    logic                       read_reg;
    logic [CNT_W-1:0]           cnt_reg;
    logic [CNT_W-1:0]           cnt_inc;
    logic                       timeout_reg;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic serving;
    logic grant_taken;

    assign i_req       = in_i_read_en | in_i_write_en;
    assign d_req       = in_d_read_en | in_d_write_en;
    assign serving     = (state_reg == ST_SERVE_I) || (state_reg == ST_SERVE_D);
    assign grant_taken = (state_reg == ST_IDLE) && (grant_i || grant_d);
    assign cnt_inc     = cnt_reg + CNT_W'(1);

`ifdef MEM_ARB_RR_EN
    logic [1:0] last_owner_reg;
    logic       last_was_d;

    assign last_was_d = (last_owner_reg == OWNER_D);

    // Remember who was granted most recently; starts as I so the first tie
    // after reset goes to D.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_reg <= OWNER_I;
        end else if (grant_taken) begin
            last_owner_reg <= grant_d ? OWNER_D : OWNER_I;
        end
    end

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_was_d (last_was_d),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );
`else
    mem_arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and all port outputs; everything is quiet outside SERVE.
    always_comb begin
        state_next         = state_reg;
        out_owner          = owner_of(state_reg);
        out_mem_read_en    = 1'b0;
        out_mem_write_en   = 1'b0;
        out_mem_addr       = 32'd0;
        out_mem_write_data = '0;
        out_i_ready        = 1'b0;
        out_i_read_data    = '0;
        out_d_ready        = 1'b0;
        out_d_read_data    = '0;

        if (serving) begin
            out_mem_read_en    = read_reg;
            out_mem_write_en   = write_reg;
            out_mem_addr       = addr_reg;
            out_mem_write_data = wdata_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                if (grant_d) begin
                    state_next = ST_SERVE_D;
                end else if (grant_i) begin
                    state_next = ST_SERVE_I;
                end
            end
            ST_SERVE_I: begin
                if (in_mem_ready) begin
                    out_i_ready     = 1'b1;
                    out_i_read_data = in_mem_read_data;
                    state_next      = ST_DONE;
                end
            end
            ST_SERVE_D: begin
                if (in_mem_ready) begin
                    out_d_ready     = 1'b1;
                    out_d_read_data = in_mem_read_data;
                    state_next      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's command in IDLE; write beats read when both are
    // raised, and the requester comes back for the read afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= 32'd0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            read_reg  <= 1'b0;
        end else if (grant_taken) begin
            if (grant_d) begin
                addr_reg  <= in_d_addr;
                wdata_reg <= in_d_write_data;
                write_reg <= in_d_write_en;
                read_reg  <= in_d_read_en & ~in_d_write_en;
            end else begin
                addr_reg  <= in_i_addr;
                wdata_reg <= in_i_write_data;
                write_reg <= in_i_write_en;
                read_reg  <= in_i_read_en & ~in_i_write_en;
            end
        end
    end

    // Watchdog: count SERVE cycles of the current grant; the flag is sticky
    // and only reports, the grant itself keeps waiting for memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else if (grant_taken) begin
            cnt_reg <= '0;
        end else if (serving) begin
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_inc;
            end
            if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign out_timeout = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table of request patterns
// with the expected grant order, a scoreboard queue of expected memory
// transactions, and hand-written watchdog / reset-in-flight sequences.
module tb_mem_arbiter;

    localparam int LW = 128;
    localparam logic [1:0] OI = 2'b01;
    localparam logic [1:0] OD = 2'b10;

    logic          clk;
    logic          reset;
    logic          in_i_read_en, in_i_write_en;
    logic [31:0]   in_i_addr;
    logic [LW-1:0] in_i_write_data;
    logic [LW-1:0] out_i_read_data;
    logic          out_i_ready;
    logic          in_d_read_en, in_d_write_en;
    logic [31:0]   in_d_addr;
    logic [LW-1:0] in_d_write_data;
    logic [LW-1:0] out_d_read_data;
    logic          out_d_ready;
    logic          out_mem_read_en, out_mem_write_en;
    logic [31:0]   out_mem_addr;
    logic [LW-1:0] out_mem_write_data;
    logic [LW-1:0] in_mem_read_data;
    logic          in_mem_ready;
    logic [1:0]    out_owner;
    logic          out_timeout;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.CACHE_LINE_SIZE(LW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in_i_read_en(in_i_read_en), .in_i_write_en(in_i_write_en),
        .in_i_addr(in_i_addr), .in_i_write_data(in_i_write_data),
        .out_i_read_data(out_i_read_data), .out_i_ready(out_i_ready),
        .in_d_read_en(in_d_read_en), .in_d_write_en(in_d_write_en),
        .in_d_addr(in_d_addr), .in_d_write_data(in_d_write_data),
        .out_d_read_data(out_d_read_data), .out_d_ready(out_d_ready),
        .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
        .out_mem_addr(out_mem_addr), .out_mem_write_data(out_mem_write_data),
        .in_mem_read_data(in_mem_read_data), .in_mem_ready(in_mem_ready),
        .out_owner(out_owner), .out_timeout(out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: both requesters' commands plus the expected grant order,
    // one character per grant: D/I = read, d/i = write, first grant leftmost.
    typedef struct {
        bit          i_rd, i_wr;
        logic [31:0] i_addr;
        int          i_reps;
        bit          d_rd, d_wr;
        logic [31:0] d_addr;
        int          d_reps;
        int          lat;
        logic [31:0] seq;
    } vec_t;

    typedef struct {
        logic [1:0]  owner;
        logic        write;
        logic [31:0] addr;
    } exp_t;

    vec_t vt[6];
    exp_t exp_q[$];
    int   i_rem, d_rem;

    function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h11};
    endfunction

    function automatic logic [LW-1:0] wr_line(input logic [31:0] a);
        return {a + 32'd3, 32'hFEED_0000, ~a, a};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input bit ird, input bit iwr, input logic [31:0] ia,
                           input int ir, input bit drd, input bit dwr, input logic [31:0] da,
                           input int dr, input int lat, input logic [31:0] seq);
        vt[idx].i_rd = ird; vt[idx].i_wr = iwr; vt[idx].i_addr = ia; vt[idx].i_reps = ir;
        vt[idx].d_rd = drd; vt[idx].d_wr = dwr; vt[idx].d_addr = da; vt[idx].d_reps = dr;
        vt[idx].lat  = lat; vt[idx].seq = seq;
    endtask

    // DONE then IDLE with no requests; memory ready is raised in DONE and
    // must be ignored.
    task automatic turnaround();
        @(negedge clk);
        in_mem_ready = 1'b1;
        #1;
        check("done_i_ready", LW'(out_i_ready), LW'(0));
        check("done_d_ready", LW'(out_d_ready), LW'(0));
        @(negedge clk);
        in_mem_ready = 1'b0;
        #1;
        check("idle_no_cmd", LW'(out_mem_read_en | out_mem_write_en), LW'(0));
        check("idle_owner", LW'(out_owner), LW'(0));
    endtask

    task automatic run_vector(input int vi);
        vec_t v;
        int n, cyc, cmd_cyc, last_rdy;
        bit first, active;
        logic [7:0] ch;
        exp_t e;
        v = vt[vi];
        n = 0;
        for (int k = 0; k < 4; k++) if (v.seq[8*k +: 8] != 8'd0) n++;
        for (int k = 0; k < n; k++) begin
            ch = v.seq[8*(n-1-k) +: 8];
            e.owner = (ch == 8'h44 || ch == 8'h64) ? OD : OI;
            e.write = (ch == 8'h64 || ch == 8'h69);
            e.addr  = (e.owner == OD) ? v.d_addr : v.i_addr;
            exp_q.push_back(e);
        end
        in_i_addr = v.i_addr; in_i_write_data = wr_line(v.i_addr);
        in_d_addr = v.d_addr; in_d_write_data = wr_line(v.d_addr);
        in_i_read_en = v.i_rd; in_i_write_en = v.i_wr; i_rem = v.i_reps;
        in_d_read_en = v.d_rd; in_d_write_en = v.d_wr; d_rem = v.d_reps;
        cyc = 0; cmd_cyc = 0; last_rdy = 0; first = 1'b1;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            active = out_mem_read_en | out_mem_write_en;
            cmd_cyc = active ? cmd_cyc + 1 : 0;
            in_mem_read_data = mem_line(out_mem_addr);
            in_mem_ready = active && (cmd_cyc == v.lat);
            #1;
            e = exp_q[0];
            if (active && cmd_cyc == 1) begin
                check("grant_owner", LW'(out_owner), LW'(e.owner));
                check("mem_addr", LW'(out_mem_addr), LW'(e.addr));
                check("mem_write_en", LW'(out_mem_write_en), LW'(e.write));
                check("mem_read_en", LW'(out_mem_read_en), LW'(!e.write));
                if (e.write) check("mem_write_data", out_mem_write_data, wr_line(e.addr));
                if (first) check("first_cmd_latency", LW'(cyc), LW'(1));
                else       check("grant_spacing", LW'(cyc - last_rdy), LW'(3));
            end
            if (!active) begin
                check("inactive_i_ready", LW'(out_i_ready), LW'(0));
                check("inactive_d_ready", LW'(out_d_ready), LW'(0));
            end
            if (out_owner != OI) check("nonowner_i_data", out_i_read_data, '0);
            if (out_owner != OD) check("nonowner_d_data", out_d_read_data, '0);
            if (out_i_ready || out_d_ready) begin
                void'(exp_q.pop_front());
                $display("vec %0d txn: owner=%0d addr=%h write=%0d cycle=%0d",
                         vi, out_owner, out_mem_addr, out_mem_write_en, cyc);
                check("ready_i", LW'(out_i_ready), LW'(e.owner == OI));
                check("ready_d", LW'(out_d_ready), LW'(e.owner == OD));
                check("read_data", (e.owner == OD) ? out_d_read_data : out_i_read_data,
                      mem_line(e.addr));
                if (out_d_ready) begin
                    d_rem--;
                    in_d_write_en = 1'b0;
                    if (d_rem <= 0) in_d_read_en = 1'b0;
                end else begin
                    i_rem--;
                    in_i_write_en = 1'b0;
                    if (i_rem <= 0) in_i_read_en = 1'b0;
                end
                cmd_cyc = 0; last_rdy = cyc; first = 1'b0;
            end
        end
        if (exp_q.size() > 0) begin
            check("vector_cycle_budget", LW'(exp_q.size()), LW'(0));
            exp_q.delete();
        end
        in_i_read_en = 1'b0; in_i_write_en = 1'b0;
        in_d_read_en = 1'b0; in_d_write_en = 1'b0;
        turnaround();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_owner"}, LW'(out_owner), LW'(0));
        check({tag, "_mem_cmd"}, LW'({out_mem_read_en, out_mem_write_en}), LW'(0));
        check({tag, "_mem_addr"}, LW'(out_mem_addr), LW'(0));
        check({tag, "_mem_wdata"}, out_mem_write_data, '0);
        check({tag, "_readies"}, LW'({out_i_ready, out_d_ready}), LW'(0));
        check({tag, "_timeout"}, LW'(out_timeout), LW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got running, required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        in_i_read_en = 0; in_i_write_en = 0; in_i_addr = 0; in_i_write_data = '0;
        in_d_read_en = 0; in_d_write_en = 0; in_d_addr = 0; in_d_write_data = '0;
        in_mem_read_data = '0; in_mem_ready = 1'b0;

        set_vec(0, 1, 0, 32'h200, 1, 0, 0, 32'h0,    0, 3, "I");
`ifdef MEM_ARB_RR_EN
        set_vec(1, 1, 0, 32'h10,  2, 1, 0, 32'h20,   2, 1, "DIDI");
        set_vec(2, 1, 0, 32'h300, 1, 1, 0, 32'h400,  1, 2, "DI");
        set_vec(3, 0, 0, 32'h0,   0, 1, 1, 32'h1000, 2, 1, "dD");
        set_vec(4, 0, 1, 32'h500, 1, 0, 1, 32'h600,  1, 3, "id");
        set_vec(5, 1, 1, 32'h700, 2, 1, 0, 32'h800,  1, 2, "iDI");
`else
        set_vec(1, 1, 0, 32'h10,  2, 1, 0, 32'h20,   2, 1, "DDII");
        set_vec(2, 1, 0, 32'h300, 1, 1, 0, 32'h400,  1, 2, "DI");
        set_vec(3, 0, 0, 32'h0,   0, 1, 1, 32'h1000, 2, 1, "dD");
        set_vec(4, 0, 1, 32'h500, 1, 0, 1, 32'h600,  1, 3, "di");
        set_vec(5, 1, 1, 32'h700, 2, 1, 0, 32'h800,  1, 2, "DiI");
`endif

        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int vi = 0; vi < 6; vi++) run_vector(vi);
        check("no_timeout_short_grants", LW'(out_timeout), LW'(0));

        // Watchdog: memory never answers a D read.
        in_d_addr = 32'h900; in_d_read_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) check("wd_addr", LW'(out_mem_addr), LW'(32'h900));
            if (c == 2) in_d_addr = 32'h1234;
            if (c == 4) check("wd_before_limit", LW'(out_timeout), LW'(0));
            if (c >= 5) check("wd_flag", LW'(out_timeout), LW'(1));
            if (c == 6) begin
                check("wd_not_aborted", LW'({out_owner, out_mem_read_en}), LW'({OD, 1'b1}));
                check("wd_addr_held", LW'(out_mem_addr), LW'(32'h900));
            end
        end
        @(negedge clk);
        in_mem_read_data = mem_line(out_mem_addr);
        in_mem_ready = 1'b1;
        #1;
        check("wd_late_ready", LW'(out_d_ready), LW'(1));
        $display("watchdog txn: owner=%0d addr=%h timeout=%0d", out_owner, out_mem_addr, out_timeout);
        in_d_read_en = 1'b0;
        turnaround();
        check("wd_sticky", LW'(out_timeout), LW'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("wd_reset");
        @(negedge clk);
        reset = 1'b0;

        // Reset while D's write is in flight: no ready pulse, all quiet.
        in_d_addr = 32'hA00; in_d_write_data = wr_line(32'hA00); in_d_write_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_owner", LW'({out_owner, out_mem_write_en}), LW'({OD, 1'b1}));
        @(negedge clk);
        in_mem_ready = 1'b1;
        #1;
        reset = 1'b1;
        in_d_write_en = 1'b0;
        #1;
        check_all_zero("rst_mid");
        $display("reset mid-serve txn: owner=%0d d_ready=%0d", out_owner, out_d_ready);
        @(negedge clk);
        reset = 1'b0;
        in_mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_release_idle", LW'({out_owner, out_mem_read_en, out_mem_write_en}), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port main-memory arbiter placed between the instruction cache (fetch stage) and the data cache and the single line-wide main memory port. Each cache presents a memory-side request of one cache line; the arbiter grants one requester at a time, drives the memory with that requester's latched command, routes `in_mem_ready` and read data back to it only, and returns to idle. Fixed data-side priority by default; round-robin when configured.

## Interface
- `CACHE_LINE_SIZE`, 128, bits per memory transfer
- `TIMEOUT_CYCLES`, 255, max cycles in a grant before `out_timeout` sets; 0 disables the watchdog
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `in_i_read_en`, `in_i_write_en`  in  1 each  I-cache request (level, held until `out_i_ready`)
- `in_i_addr`  in  32  I-cache line address
- `in_i_write_data`  in  CACHE_LINE_SIZE  I-cache write line
- `out_i_read_data`  out  CACHE_LINE_SIZE  line returned to I-cache
- `out_i_ready`  out  1  one-cycle completion pulse to I-cache
- `in_d_read_en`, `in_d_write_en`, `in_d_addr`, `in_d_write_data`  in  1/1/32/CACHE_LINE_SIZE  D-cache request, same rules as I-side
- `out_d_read_data`, `out_d_ready`  out  CACHE_LINE_SIZE/1  D-cache response
- `out_mem_read_en`, `out_mem_write_en`  out  1 each  memory command
- `out_mem_addr`  out  32  memory address
- `out_mem_write_data`  out  CACHE_LINE_SIZE  memory write line
- `in_mem_read_data`  in  CACHE_LINE_SIZE  memory read line
- `in_mem_ready`  in  1  memory completion
- `out_owner`  out  2  00 none, 01 I, 10 D
- `out_timeout`  out  1  sticky watchdog flag

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: sample requests. A side requests when `read_en | write_en`. Winner per policy → SERVE_x next edge. Latch the winner's addr, write data, and command (`write_en` has precedence; if both are set, the transaction is a write and the requester re-requests for the read).
- SERVE_x: drive `out_mem_*` from latched registers. `out_owner` reflects x. When `in_mem_ready`=1: `out_x_ready`=1 (combinational, this cycle only), `out_x_read_data`=`in_mem_read_data`; → DONE.
- DONE: one turnaround cycle, no sampling, memory command low; → IDLE. Gives the requester one edge to drop or change its request.
- Non-owner ready is always 0; its read data is 0.
- `in_mem_ready` in IDLE/DONE is ignored.
- Default policy: D wins whenever it requests (D stall freezes the whole pipeline).
- Watchdog: 8-bit-or-wider counter clears on entry to SERVE_x and increments each SERVE cycle; when it reaches `TIMEOUT_CYCLES`, `out_timeout` is set (sticky until reset). The grant is not aborted.

## Timing
- Reset (async): state IDLE, all `out_*` 0, latched regs 0, counter 0, `out_timeout` 0, last owner = I.
- Request high at edge N in IDLE → memory command visible from cycle N+1.
- Memory latency L cycles in SERVE → ready to the requester in the same cycle as `in_mem_ready`.
- Minimum spacing between two grants: SERVE, DONE, IDLE = 3 cycles after ready.
- Request changes after latch do not affect the in-flight transaction.
- Reset mid-SERVE: transaction abandoned, no ready pulse; memory must tolerate the dropped command.
- Both requests in the same IDLE cycle: policy decides; the loser stays pending and is granted on the next IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. Last-owner register updated on entry to SERVE_x; on a tie, the side not served last wins (first tie after reset goes to D). Single requesters are granted immediately.
- Not defined: fixed D-over-I priority, no last-owner register; I can starve under continuous D traffic.

## Structure
- `mem_arb_pkg`: state enum, owner encoding constants (`OWNER_NONE`/`OWNER_I`/`OWNER_D`), default line size.
- Sub-module `mem_arb_pick`: combinational winner select from two requests plus last owner (policy lives here only).

## Test plan
- I read of addr 0x200 alone, memory ready after 3 SERVE cycles → `out_mem_addr`=0x200 from cycle 1; `out_i_ready` for one cycle with data; `out_d_ready` stays 0.
- I and D requesting in the same cycle, no RR → D granted first; I granted 3 cycles after D's ready.
- Same stimulus with `MEM_ARB_RR_EN`, repeated 4 times → grants alternate D, I, D, I.
- D asserts read+write on 0x1000 → `out_mem_write_en`=1, read_en=0; held read is granted as a second transaction.
- Memory never ready, `TIMEOUT_CYCLES`=4 → `out_timeout`=1 after 4 SERVE cycles and stays 1; reset clears all outputs.
- Reset asserted mid-SERVE_D → outputs 0 immediately, no ready pulse, IDLE after release.
